// File: rtl/can_pkg.sv
// Shared CAN packet definitions: widths, packed record layout and field offsets
// used by the RX packet buffer and the TX packer.
package can_pkg;
  localparam int CAN_ID_W      = 29;
  localparam int CAN_MAX_BYTES = 8;
  localparam int CAN_LEN_W     = 4;
  localparam int CAN_DATA_W    = CAN_MAX_BYTES * 8;

  // Record layout, LSB first: data | len | ide | id | status
  localparam int PKT_DATA_LSB = 0;
  localparam int PKT_LEN_LSB  = PKT_DATA_LSB + CAN_DATA_W;
  localparam int PKT_IDE_BIT  = PKT_LEN_LSB + CAN_LEN_W;
  localparam int PKT_ID_LSB   = PKT_IDE_BIT + 1;
  localparam int PKT_STAT_BIT = PKT_ID_LSB + CAN_ID_W;
  localparam int PKT_REC_W    = PKT_STAT_BIT + 1;

  typedef struct packed {
    logic                  status;  // set when bytes beyond the 8th were discarded
    logic [CAN_ID_W-1:0]   id;
    logic                  ide;
    logic [CAN_LEN_W-1:0]  len;
    logic [CAN_DATA_W-1:0] data;
  } can_pkt_t;

  function automatic logic [CAN_DATA_W-1:0] put_byte(input logic [CAN_DATA_W-1:0] d,
                                                     input logic [2:0] lane,
                                                     input logic [7:0] b);
    logic [CAN_DATA_W-1:0] r;
    r = d;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/can_pkt_slot_fifo.sv
// Generic synchronous slot FIFO; a push into a full FIFO is still accepted
// when the head is popped on the same edge.
module can_pkt_slot_fifo #(
  parameter int W          = 99,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_ok,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LAST_C  = (DEPTH_LOG2+1)'(DEPTH - 1);

  logic [W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, occ;
  logic                full, pop;

  assign full      = (occ == DEPTH_C);
  assign pop_valid = (occ != '0);
  assign pop       = pop_valid & pop_ready;
  assign push_ok   = push & (~full | pop);
  assign pop_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Slot storage carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end
endmodule

// File: rtl/can_rx_pkt_buffer.sv
// Assembles can_top's RX byte stream into packet records and queues them for the host.
// Define CAN_RX_PKT_BUF_STATS_EN to build the saturating drop counter.
module can_rx_pkt_buffer
  import can_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  input  logic [7:0]            rx_data,
  input  logic [CAN_ID_W-1:0]   rx_id,
  input  logic                  rx_ide,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [CAN_ID_W-1:0]   pkt_id,
  output logic                  pkt_ide,
  output logic [CAN_LEN_W-1:0]  pkt_len,
  output logic [CAN_DATA_W-1:0] pkt_data,
  output logic [15:0]           drop_cnt
);
  logic [CAN_LEN_W-1:0]  asm_len, beat_len;
  logic [CAN_DATA_W-1:0] asm_data, beat_data;
  logic                  trunc, beat_trunc, lane_free;
  logic                  commit, push_ok;
  can_pkt_t              rec, head;
  logic                  unused_status;

  // State as it would be after absorbing this beat's byte
  assign lane_free  = (asm_len < CAN_LEN_W'(CAN_MAX_BYTES));
  assign beat_data  = lane_free ? put_byte(asm_data, asm_len[2:0], rx_data) : asm_data;
  assign beat_len   = lane_free ? asm_len + 1'b1 : asm_len;
  assign beat_trunc = trunc | ~lane_free;
  assign commit     = rx_valid & rx_last;

  always_comb begin
    rec        = '0;
    rec.status = beat_trunc;
    rec.id     = rx_id;
    rec.ide    = rx_ide;
    rec.len    = beat_len;
    rec.data   = beat_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      asm_len  <= '0;
      asm_data <= '0;
      trunc    <= 1'b0;
    end else if (rx_valid) begin
      if (rx_last) begin
        asm_len  <= '0;
        asm_data <= '0;
        trunc    <= 1'b0;
      end else begin
        asm_len  <= beat_len;
        asm_data <= beat_data;
        trunc    <= beat_trunc;
      end
    end
  end

  can_pkt_slot_fifo #(.W(PKT_REC_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (commit),
    .push_data (rec),
    .push_ok   (push_ok),
    .pop_valid (pkt_valid),
    .pop_ready (pkt_ready),
    .pop_data  (head)
  );

  // Slot RAM is unreset, so the head is masked whenever nothing is queued
  assign pkt_id        = pkt_valid ? head.id   : '0;
  assign pkt_ide       = pkt_valid ? head.ide  : 1'b0;
  assign pkt_len       = pkt_valid ? head.len  : '0;
  assign pkt_data      = pkt_valid ? head.data : '0;
  assign unused_status = head.status;

`ifdef CAN_RX_PKT_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn)                                     drop_cnt <= '0;
    else if (commit && !push_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end
`else
  assign drop_cnt = 16'd0;
`endif
endmodule
